// File: rtl/rr_mux_four_if.sv
// Handshake bundle for the rr_mux_four 4-to-1 gathering multiplexer.
// slave: the mux side; master: the side that drives the inputs and consumes the output.
interface rr_mux_four_if #(parameter int WIDTH = 8);
   logic [3:0]         in_valid;
   logic [4*WIDTH-1:0] in_data;
   logic [3:0]         in_ready;
   logic               out_valid;
   logic [WIDTH-1:0]   out_data;
   logic [1:0]         out_sel;
   logic               out_ready;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_sel
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_sel
   );
endinterface

// File: rtl/rr_mux_four.sv
// 4-to-1 registered multiplexer with round-robin arbitration and valid/ready handshakes.
// Define RR_MUX_FIXED_PRIO_EN for fixed priority A>B>C>D instead of round-robin.
module rr_mux_four #(
   parameter int WIDTH = 8
) (
   input logic         clk,
   input logic         reset,
   rr_mux_four_if.slave bus
);

   logic             load_s;
   logic [3:0]       grant_s;
   logic [1:0]       gidx_s;
   logic             gnt_any_s;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [1:0]       out_sel_q, out_sel_d;
`ifndef RR_MUX_FIXED_PRIO_EN
   logic [1:0]       rr_ptr_q, rr_ptr_d;
   logic [1:0]       srch_idx_s;
   logic             found_s;
`endif

   // Output register can take a word when empty or being drained this cycle.
   assign load_s = !out_valid_q || bus.out_ready;

`ifdef RR_MUX_FIXED_PRIO_EN
   // Fixed-priority grant, A highest.
   always_comb begin
      grant_s = 4'b0000;
      gidx_s  = 2'b00;
      if (bus.in_valid[0]) begin
         grant_s = 4'b0001;
         gidx_s  = 2'b00;
      end else if (bus.in_valid[1]) begin
         grant_s = 4'b0010;
         gidx_s  = 2'b01;
      end else if (bus.in_valid[2]) begin
         grant_s = 4'b0100;
         gidx_s  = 2'b10;
      end else if (bus.in_valid[3]) begin
         grant_s = 4'b1000;
         gidx_s  = 2'b11;
      end else begin
         grant_s = 4'b0000;
      end
   end
`else
   // Round-robin grant: search starts just after the last granted channel, wrapping mod 4.
   always_comb begin
      grant_s    = 4'b0000;
      gidx_s     = 2'b00;
      found_s    = 1'b0;
      srch_idx_s = 2'b00;
      for (int k = 1; k <= 4; k++) begin
         srch_idx_s = rr_ptr_q + 2'(k);
         if (!found_s && bus.in_valid[srch_idx_s]) begin
            grant_s[srch_idx_s] = 1'b1;
            gidx_s              = srch_idx_s;
            found_s             = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end
`endif

   assign gnt_any_s    = |grant_s;
   assign bus.in_ready = (load_s && !reset) ? grant_s : 4'b0000;

   // Next-state for the output stage and arbitration pointer.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
`ifndef RR_MUX_FIXED_PRIO_EN
      rr_ptr_d    = rr_ptr_q;
`endif
      if (load_s) begin
         out_valid_d = gnt_any_s;
         if (gnt_any_s) begin
            out_data_d = bus.in_data[gidx_s*WIDTH +: WIDTH];
            out_sel_d  = gidx_s;
`ifndef RR_MUX_FIXED_PRIO_EN
            rr_ptr_d   = gidx_s;
`endif
         end else begin
            out_data_d = out_data_q;
         end
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   // Output register and pointer; reset discards any held word and restores A-first priority.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= 2'b00;
`ifndef RR_MUX_FIXED_PRIO_EN
         rr_ptr_q    <= 2'b11;
`endif
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
`ifndef RR_MUX_FIXED_PRIO_EN
         rr_ptr_q    <= rr_ptr_d;
`endif
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_four.sv
// Self-checking bench for rr_mux_four: a reference arbiter model feeds a scoreboard of
// expected {sel,data} words, plus directed checks for reset, ordering, backpressure and wrap.
module tb_rr_mux_four;
   localparam int W = 8;

   logic clk;
   logic reset;
   int   checks_cnt;
   int   errors_cnt;

   rr_mux_four_if #(.WIDTH(W)) bus ();

   rr_mux_four #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // model state
   logic        m_ov;
   logic [1:0]  m_ptr;
   logic [3:0]  last_xfer;
   logic [9:0]  sb_q[$];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks_cnt++;
      if (obs !== exp) begin
         errors_cnt++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Returns {found, index}; first valid channel in order ptr+1 .. ptr+4.
   function automatic logic [2:0] model_pick(input logic [3:0] v, input logic [1:0] p);
      logic [1:0] idx;
      logic [2:0] r;
      r = 3'b000;
      for (int k = 4; k >= 1; k--) begin
         idx = p + 2'(k);
         if (v[idx]) r = {1'b1, idx};
      end
      return r;
   endfunction

   task automatic check_cycle();
      logic [2:0] pk;
      logic [3:0] exp_rdy;
      logic [9:0] fr;
      pk = model_pick(bus.in_valid, m_ptr);
      exp_rdy = (!reset && (!m_ov || bus.out_ready) && pk[2]) ? (4'b0001 << pk[1:0]) : 4'b0000;
      check_eq("in_ready", {28'd0, bus.in_ready}, {28'd0, exp_rdy});
      check_eq("out_valid", {31'd0, bus.out_valid}, {31'd0, m_ov});
      if (m_ov) begin
         if (sb_q.size() == 0) begin
            check_eq("sb_empty", 32'd1, 32'd0);
         end else begin
            fr = sb_q[0];
            check_eq("out_data", {24'd0, bus.out_data}, {24'd0, fr[7:0]});
            check_eq("out_sel", {30'd0, bus.out_sel}, {30'd0, fr[9:8]});
         end
      end
   endtask

   task automatic update_model();
      logic [2:0] pk;
      logic       ld;
      if (reset) begin
         sb_q.delete();
         m_ov      = 1'b0;
         m_ptr     = 2'b11;
         last_xfer = 4'b0000;
      end else begin
         ld = !m_ov || bus.out_ready;
         pk = model_pick(bus.in_valid, m_ptr);
         if (m_ov && bus.out_ready && sb_q.size() > 0) void'(sb_q.pop_front());
         if (ld && pk[2]) begin
            sb_q.push_back({pk[1:0], bus.in_data[pk[1:0]*W +: W]});
            m_ov      = 1'b1;
            last_xfer = 4'b0001 << pk[1:0];
`ifndef RR_MUX_FIXED_PRIO_EN
            m_ptr     = pk[1:0];
`endif
         end else begin
            last_xfer = 4'b0000;
            if (ld) m_ov = 1'b0;
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      check_cycle();
      @(posedge clk);
      update_model();
      #1;
   endtask

   task automatic set_in(input logic [3:0] v, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d, input logic rdy);
      bus.in_valid  = v;
      bus.in_data   = {d, c, b, a};
      bus.out_ready = rdy;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   logic [1:0] exp_sel;
   logic [7:0] rnd_byte;

   initial begin
      checks_cnt = 0;
      errors_cnt = 0;
      m_ov = 1'b0;
      m_ptr = 2'b11;
      last_xfer = 4'b0000;
      reset = 1'b1;
      set_in(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
      @(posedge clk);
      #1;
      do_reset();
      check_eq("rst_valid", {31'd0, bus.out_valid}, 32'd0);
      check_eq("rst_data", {24'd0, bus.out_data}, 32'd0);
      check_eq("rst_sel", {30'd0, bus.out_sel}, 32'd0);

      // single A word
      set_in(4'b0001, 8'h3C, 8'h00, 8'h00, 8'h00, 1'b1);
      #1;
      check_eq("t1_rdy", {28'd0, bus.in_ready}, 32'h1);
      tick();
      set_in(4'b0000, 8'h3C, 8'h00, 8'h00, 8'h00, 1'b1);
      check_eq("t1_valid", {31'd0, bus.out_valid}, 32'd1);
      check_eq("t1_data", {24'd0, bus.out_data}, 32'h3C);
      check_eq("t1_sel", {30'd0, bus.out_sel}, 32'd0);
      tick();

      // all four valid, no bubbles
      do_reset();
      set_in(4'b1111, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 1'b1);
      for (int i = 0; i < 5; i++) begin
         tick();
`ifdef RR_MUX_FIXED_PRIO_EN
         exp_sel = 2'b00;
`else
         exp_sel = 2'(i % 4);
`endif
         check_eq("rr_valid", {31'd0, bus.out_valid}, 32'd1);
         check_eq("rr_sel", {30'd0, bus.out_sel}, {30'd0, exp_sel});
         check_eq("rr_data", {24'd0, bus.out_data}, {30'd0, exp_sel} + 32'h0A);
      end
      set_in(4'b0000, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 1'b1);
      tick();

      // backpressure: C word held while B waits
      set_in(4'b0100, 8'h00, 8'h77, 8'h55, 8'h00, 1'b1);
      tick();
      set_in(4'b0010, 8'h00, 8'h77, 8'h55, 8'h00, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("bp_data", {24'd0, bus.out_data}, 32'h55);
         check_eq("bp_sel", {30'd0, bus.out_sel}, 32'd2);
         check_eq("bp_rdy", {28'd0, bus.in_ready}, 32'd0);
      end
      bus.out_ready = 1'b1;
      tick();
      check_eq("bp_rel_sel", {30'd0, bus.out_sel}, 32'd1);
      check_eq("bp_rel_data", {24'd0, bus.out_data}, 32'h77);

      // wrap: B last, A and D valid -> D then A
      set_in(4'b1001, 8'h11, 8'h00, 8'h00, 8'hDD, 1'b1);
      tick();
`ifdef RR_MUX_FIXED_PRIO_EN
      check_eq("wrap_first", {30'd0, bus.out_sel}, 32'd0);
`else
      check_eq("wrap_first", {30'd0, bus.out_sel}, 32'd3);
`endif
      tick();
      check_eq("wrap_second", {30'd0, bus.out_sel}, 32'd0);
      set_in(4'b0000, 8'h11, 8'h00, 8'h00, 8'hDD, 1'b1);
      tick();

      // reset mid-stream with a held word and pending inputs
      set_in(4'b1111, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 1'b1);
      tick();
      bus.out_ready = 1'b0;
      tick();
      check_eq("mid_held", {31'd0, bus.out_valid}, 32'd1);
      reset = 1'b1;
      #1;
      check_eq("mid_rdy", {28'd0, bus.in_ready}, 32'd0);
      tick();
      check_eq("mid_valid", {31'd0, bus.out_valid}, 32'd0);
      reset = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      check_eq("mid_first", {30'd0, bus.out_sel}, 32'd0);
      check_eq("mid_data", {24'd0, bus.out_data}, 32'hA1);

      // A and C valid continuously (A granted last)
      set_in(4'b0101, 8'h1A, 8'h00, 8'h1C, 8'h00, 1'b1);
      for (int i = 0; i < 4; i++) begin
         tick();
`ifdef RR_MUX_FIXED_PRIO_EN
         exp_sel = 2'b00;
`else
         exp_sel = (i % 2 == 0) ? 2'b10 : 2'b00;
`endif
         check_eq("ac_sel", {30'd0, bus.out_sel}, {30'd0, exp_sel});
      end
      bus.in_valid = 4'b0100;
      tick();
      check_eq("ac_c_only", {30'd0, bus.out_sel}, 32'd2);
      bus.in_valid = 4'b0000;
      tick();

      // random traffic against the scoreboard; data held while a channel waits
      for (int n = 0; n < 400; n++) begin
         for (int ch = 0; ch < 4; ch++) begin
            if (!(bus.in_valid[ch] && !last_xfer[ch])) begin
               bus.in_valid[ch] = ($urandom_range(0, 2) != 0);
               rnd_byte = 8'($urandom_range(0, 255));
               bus.in_data[ch*W +: W] = rnd_byte;
            end
         end
         bus.out_ready = ($urandom_range(0, 3) != 0);
         if (n == 200) reset = 1'b1;
         else reset = 1'b0;
         tick();
      end
      bus.in_valid  = 4'b0000;
      bus.out_ready = 1'b1;
      tick();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
      $finish;
   end

endmodule
